// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline hazard/stall controller: load-use, redirect flush, MEM wait with timeout
// Optional PIPE_CTRL_PERF_EN adds stall/flush event counters.
module pipe_ctrl #(
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic              i_clock,
  input  logic              i_reset_x,
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic              i_id_use_rs1,
  input  logic              i_id_use_rs2,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic              i_ex_memread,
  input  logic              i_ex_redirect,
  input  logic              i_mem_req,
  input  logic              i_mem_ack,
  output logic              o_pc_en,
  output logic              o_ifid_en,
  output logic              o_ifid_clr,
  output logic              o_idex_en,
  output logic              o_idex_clr,
  output logic              o_exmem_en,
  output logic              o_exmem_clr,
  output logic              o_memwb_en,
  output logic              o_memwb_clr,
  output logic              o_err,
  output logic [1:0]        o_state
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]       o_stall_cnt,
  output logic [31:0]       o_flush_cnt
`endif
);

  localparam logic [1:0] S_INIT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_ERROR = 2'd3;
  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  logic [1:0] state_q, state_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic       in_run, in_wait, active, mem_stall, load_use;

  // In MEM_WAIT the outstanding request is implied; only the ack matters.
  assign in_run    = (state_q == S_RUN);
  assign in_wait   = (state_q == S_WAIT);
  assign active    = in_run | in_wait;
  assign mem_stall = (in_run & i_mem_req & ~i_mem_ack) | (in_wait & ~i_mem_ack);
  assign load_use  = i_ex_memread & (i_ex_rd != '0) &
                     ((i_id_use_rs1 & (i_id_rs1 == i_ex_rd)) |
                      (i_id_use_rs2 & (i_id_rs2 == i_ex_rd)));

  always_ff @(posedge i_clock or negedge i_reset_x) begin
    if (!i_reset_x) begin
      state_q <= S_INIT;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_INIT: state_d = S_RUN;
      S_RUN: begin
        if (mem_stall) begin
          state_d = S_WAIT;
          wcnt_d  = 8'd1;
        end
      end
      S_WAIT: begin
        if (i_mem_ack) begin
          state_d = S_RUN;
          wcnt_d  = '0;
        end else if (wcnt_q == TIMEOUT) begin
          state_d = S_ERROR;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    o_pc_en     = 1'b0;
    o_ifid_en   = 1'b0;
    o_ifid_clr  = 1'b0;
    o_idex_en   = 1'b0;
    o_idex_clr  = 1'b0;
    o_exmem_en  = 1'b0;
    o_exmem_clr = 1'b0;
    o_memwb_en  = 1'b0;
    o_memwb_clr = 1'b0;
    if (state_q == S_INIT) begin
      o_ifid_en   = 1'b1;
      o_ifid_clr  = 1'b1;
      o_idex_en   = 1'b1;
      o_idex_clr  = 1'b1;
      o_exmem_en  = 1'b1;
      o_exmem_clr = 1'b1;
      o_memwb_en  = 1'b1;
      o_memwb_clr = 1'b1;
    end else if (active) begin
      // Bubble into WB while the MEM stage is frozen.
      if (mem_stall) begin
        o_memwb_en  = 1'b1;
        o_memwb_clr = 1'b1;
      end else begin
        o_pc_en    = 1'b1;
        o_ifid_en  = 1'b1;
        o_idex_en  = 1'b1;
        o_exmem_en = 1'b1;
        o_memwb_en = 1'b1;
        if (i_ex_redirect) begin
          o_ifid_clr = 1'b1;
          o_idex_clr = 1'b1;
        end else if (load_use) begin
          o_pc_en    = 1'b0;
          o_ifid_en  = 1'b0;
          o_idex_clr = 1'b1;
        end
      end
    end
  end

  assign o_err   = (state_q == S_ERROR);
  assign o_state = state_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge i_clock or negedge i_reset_x) begin
    if (!i_reset_x) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (active & ~o_pc_en) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (active & ~mem_stall & i_ex_redirect) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;
`endif

endmodule
